// File: rtl/pc_pkg.sv
// Shared PC defaults: width, reset vector and instruction size.
package pc_pkg;
    localparam int          PC_XLEN         = 32;
    localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;
    localparam int          INSN_BYTES      = 4;
    localparam int          INSN_ALIGN_BITS = 2;
endpackage

// File: rtl/pc_trace.sv
// PC trace: previous PC and wrapping load counter; updates with each PC load.
// Latency 1 cycle, no backpressure (every clock edge out of reset is a load).
module pc_trace
    import pc_pkg::*;
#(
    parameter int              XLEN         = PC_XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(PC_RESET_VECTOR)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] i_cur_pc,
    output logic [XLEN-1:0] o_prev_pc,
    output logic [31:0]     o_load_count
);

    logic [XLEN-1:0] r_prev_pc;
    logic [31:0]     r_load_count;

    // i_cur_pc is the value about to be replaced by this edge's load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prev_pc    <= RESET_VECTOR;
            r_load_count <= 32'd0;
        end else begin
            r_prev_pc    <= i_cur_pc;
            r_load_count <= r_load_count + 32'd1;
        end
    end

    assign o_prev_pc    = r_prev_pc;
    assign o_load_count = r_load_count;

endmodule

// File: rtl/pc.sv
// Program counter: loads word-aligned next_pc every edge (1-cycle latency, no stall).
// Optional trace outputs prev_pc/load_count when PC_TRACE_EN is defined.
module pc
    import pc_pkg::*;
#(
    parameter int              XLEN         = PC_XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(PC_RESET_VECTOR)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] next_pc,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus4,
    output logic            pc_valid,
    output logic            misaligned
`ifdef PC_TRACE_EN
    ,
    output logic [XLEN-1:0] prev_pc,
    output logic [31:0]     load_count
`endif
);

    logic [XLEN-1:0] r_pc;
    logic            r_valid;
    logic            r_misaligned;
    logic [XLEN-1:0] w_next_aligned;
    logic            w_next_misaligned;

    assign w_next_aligned    = {next_pc[XLEN-1:INSN_ALIGN_BITS], {INSN_ALIGN_BITS{1'b0}}};
    assign w_next_misaligned = |next_pc[INSN_ALIGN_BITS-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc         <= RESET_VECTOR;
            r_valid      <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            r_pc         <= w_next_aligned;
            r_valid      <= 1'b1;
            r_misaligned <= w_next_misaligned;
        end
    end

    // Wraps modulo 2^XLEN; carry-out is deliberately dropped.
    assign pc_plus4   = r_pc + XLEN'(INSN_BYTES);
    assign pc_out     = r_pc;
    assign pc_valid   = r_valid;
    assign misaligned = r_misaligned;

`ifdef PC_TRACE_EN
    pc_trace #(
        .XLEN         (XLEN),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_trace (
        .clk          (clk),
        .reset        (reset),
        .i_cur_pc     (r_pc),
        .o_prev_pc    (prev_pc),
        .o_load_count (load_count)
    );
`endif

endmodule

// File: tb/tb_pc.sv
// Directed-vector bench for the program counter.
module tb_pc;

    logic        clk;
    logic        reset;
    logic [31:0] next_pc;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        pc_valid;
    logic        misaligned;
`ifdef PC_TRACE_EN
    logic [31:0] prev_pc;
    logic [31:0] load_count;
`endif

    int n_vec = 0;
    int n_bad = 0;

    pc #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .next_pc    (next_pc),
        .pc_out     (pc_out),
        .pc_plus4   (pc_plus4),
        .pc_valid   (pc_valid),
        .misaligned (misaligned)
`ifdef PC_TRACE_EN
        ,
        .prev_pc    (prev_pc),
        .load_count (load_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic edge_settle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        next_pc = 32'h0000_0040;
        repeat (3) edge_settle();
        n_vec++;
        if (pc_out !== 32'h0) begin
            $display("FAIL reset_pc_out got=%h exp=%h", pc_out, 32'h0); n_bad++;
        end
        n_vec++;
        if (pc_plus4 !== 32'h4) begin
            $display("FAIL reset_pc_plus4 got=%h exp=%h", pc_plus4, 32'h4); n_bad++;
        end
        n_vec++;
        if (pc_valid !== 1'b0) begin
            $display("FAIL reset_pc_valid got=%b exp=0", pc_valid); n_bad++;
        end
        n_vec++;
        if (misaligned !== 1'b0) begin
            $display("FAIL reset_misaligned got=%b exp=0", misaligned); n_bad++;
        end
    endtask

    task automatic test_sequential();
        logic [31:0] vals [4];
        vals[0] = 32'h4; vals[1] = 32'h8; vals[2] = 32'hC; vals[3] = 32'h10;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            next_pc = vals[i];
            n_vec++;
            if (i > 0 && pc_out !== vals[i-1]) begin
                $display("FAIL seq_hold[%0d] got=%h exp=%h", i, pc_out, vals[i-1]); n_bad++;
            end
            edge_settle();
            n_vec++;
            if (pc_out !== vals[i]) begin
                $display("FAIL seq_pc_out[%0d] got=%h exp=%h", i, pc_out, vals[i]); n_bad++;
            end
            n_vec++;
            if (pc_plus4 !== vals[i] + 32'd4) begin
                $display("FAIL seq_pc_plus4[%0d] got=%h exp=%h", i, pc_plus4, vals[i] + 32'd4); n_bad++;
            end
            n_vec++;
            if (pc_valid !== 1'b1) begin
                $display("FAIL seq_pc_valid[%0d] got=%b exp=1", i, pc_valid); n_bad++;
            end
            n_vec++;
            if (misaligned !== 1'b0) begin
                $display("FAIL seq_misaligned[%0d] got=%b exp=0", i, misaligned); n_bad++;
            end
        end
    endtask

    task automatic test_misalign();
        next_pc = 32'h0000_0106;
        edge_settle();
        n_vec++;
        if (pc_out !== 32'h0000_0104) begin
            $display("FAIL mis_pc_out got=%h exp=%h", pc_out, 32'h0000_0104); n_bad++;
        end
        n_vec++;
        if (misaligned !== 1'b1) begin
            $display("FAIL mis_flag_set got=%b exp=1", misaligned); n_bad++;
        end
        next_pc = 32'h0000_0108;
        edge_settle();
        n_vec++;
        if (pc_out !== 32'h0000_0108) begin
            $display("FAIL mis_next_pc_out got=%h exp=%h", pc_out, 32'h0000_0108); n_bad++;
        end
        n_vec++;
        if (misaligned !== 1'b0) begin
            $display("FAIL mis_flag_clear got=%b exp=0", misaligned); n_bad++;
        end
    endtask

    task automatic test_wrap();
        next_pc = 32'hFFFF_FFFF;
        edge_settle();
        n_vec++;
        if (pc_out !== 32'hFFFF_FFFC) begin
            $display("FAIL ones_pc_out got=%h exp=%h", pc_out, 32'hFFFF_FFFC); n_bad++;
        end
        n_vec++;
        if (misaligned !== 1'b1) begin
            $display("FAIL ones_misaligned got=%b exp=1", misaligned); n_bad++;
        end
        n_vec++;
        if (pc_plus4 !== 32'h0) begin
            $display("FAIL ones_pc_plus4 got=%h exp=%h", pc_plus4, 32'h0); n_bad++;
        end
        next_pc = 32'hFFFF_FFFC;
        edge_settle();
        n_vec++;
        if (pc_plus4 !== 32'h0 || misaligned !== 1'b0) begin
            $display("FAIL wrap_pc_plus4 got=%h/%b exp=%h/0", pc_plus4, misaligned, 32'h0); n_bad++;
        end
        next_pc = 32'h0;
        edge_settle();
        n_vec++;
        if (pc_out !== 32'h0 || pc_plus4 !== 32'h4) begin
            $display("FAIL zero_load got=%h/%h exp=%h/%h", pc_out, pc_plus4, 32'h0, 32'h4); n_bad++;
        end
    endtask

    task automatic test_midrun_reset();
        next_pc = 32'h0000_0011;
        edge_settle();
        n_vec++;
        if (pc_out !== 32'h10 || misaligned !== 1'b1) begin
            $display("FAIL mid_preload got=%h/%b exp=%h/1", pc_out, misaligned, 32'h10); n_bad++;
        end
        #2;
        reset = 1'b0;
        #1;
        n_vec++;
        if (pc_out !== 32'h0 || pc_plus4 !== 32'h4) begin
            $display("FAIL mid_async_pc got=%h/%h exp=%h/%h", pc_out, pc_plus4, 32'h0, 32'h4); n_bad++;
        end
        n_vec++;
        if (pc_valid !== 1'b0 || misaligned !== 1'b0) begin
            $display("FAIL mid_async_flags got=%b/%b exp=0/0", pc_valid, misaligned); n_bad++;
        end
        next_pc = 32'h0000_0020;
        edge_settle();
        n_vec++;
        if (pc_out !== 32'h0 || pc_valid !== 1'b0) begin
            $display("FAIL mid_edge_ignored got=%h/%b exp=%h/0", pc_out, pc_valid, 32'h0); n_bad++;
        end
        reset = 1'b1;
        #1;
        n_vec++;
        if (pc_out !== 32'h0) begin
            $display("FAIL mid_release_no_edge got=%h exp=%h", pc_out, 32'h0); n_bad++;
        end
        edge_settle();
        n_vec++;
        if (pc_out !== 32'h20 || pc_valid !== 1'b1) begin
            $display("FAIL mid_first_load got=%h/%b exp=%h/1", pc_out, pc_valid, 32'h20); n_bad++;
        end
    endtask

`ifdef PC_TRACE_EN
    task automatic test_trace();
        reset = 1'b0;
        #1;
        n_vec++;
        if (prev_pc !== 32'h0 || load_count !== 32'h0) begin
            $display("FAIL trace_reset got=%h/%0d exp=0/0", prev_pc, load_count); n_bad++;
        end
        edge_settle();
        reset   = 1'b1;
        next_pc = 32'h4;
        edge_settle();
        next_pc = 32'h8;
        edge_settle();
        n_vec++;
        if (prev_pc !== 32'h4) begin
            $display("FAIL trace_prev_pc got=%h exp=%h", prev_pc, 32'h4); n_bad++;
        end
        n_vec++;
        if (load_count !== 32'd2) begin
            $display("FAIL trace_load_count got=%0d exp=2", load_count); n_bad++;
        end
        #2;
        reset = 1'b0;
        #1;
        n_vec++;
        if (prev_pc !== 32'h0 || load_count !== 32'h0) begin
            $display("FAIL trace_rereset got=%h/%0d exp=0/0", prev_pc, load_count); n_bad++;
        end
        edge_settle();
        reset = 1'b1;
    endtask
`endif

    initial begin
        reset   = 1'b0;
        next_pc = 32'h0;
        test_reset();
        test_sequential();
        test_misalign();
        test_wrap();
        test_midrun_reset();
`ifdef PC_TRACE_EN
        test_trace();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pc.md
PC -- requirements
Module: pc

Interface
- REQ-001 SHALL have parameter XLEN, default 32: PC width in bits.
- REQ-002 SHALL have parameter RESET_VECTOR, default 32'h0000_0000: value of pc_out under reset.
- REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
- REQ-004 SHALL have port reset, input, 1 bit: reset is asynchronous and active-low, named reset; 0 = in reset.
- REQ-005 SHALL have port next_pc, input, XLEN bits: address to load on every clock edge.
- REQ-006 SHALL have port pc_out, output, XLEN bits: registered current PC.
- REQ-007 SHALL have port pc_plus4, output, XLEN bits: combinational pc_out + 4.
- REQ-008 SHALL have port pc_valid, output, 1 bit: registered; 1 once at least one load has occurred since reset release.
- REQ-009 SHALL have port misaligned, output, 1 bit: registered; next_pc[1:0] != 0 at the last load.

Function
- REQ-010 SHALL load pc_out <= {next_pc[XLEN-1:2], 2'b00} on every rising clk edge with reset high; no enable, no stall.
- REQ-011 SHALL have one-cycle latency: next_pc applied before edge N appears on pc_out after edge N.
- REQ-012 SHALL clear low two bits on load; misaligned SHALL be 1 for exactly the cycles following a load with next_pc[1:0] != 0, 0 otherwise.
- REQ-013 SHALL compute pc_plus4 modulo 2^XLEN; 32'hFFFF_FFFC yields 32'h0000_0000, no carry-out flag.
- REQ-014 SHALL accept any next_pc value including 0 and all-ones (all-ones loads 32'hFFFF_FFFC, misaligned=1).
- REQ-015 SHALL set pc_valid to 1 at the first rising edge after reset deassertion and hold it until next reset.

Reset
- REQ-016 SHALL, while reset=0, immediately (no clock) force pc_out=RESET_VECTOR, pc_valid=0, misaligned=0; pc_plus4=RESET_VECTOR+4.
- REQ-017 SHALL ignore clk edges while reset=0; an assertion mid-run overrides any load in progress.
- REQ-018 SHALL require reset deassertion synchronous to clk by the environment; the first load occurs at the first rising edge with reset=1.

Configuration
- REQ-019 SHALL, when macro PC_TRACE_EN is defined, add outputs prev_pc (XLEN, pc_out value before the last load, RESET_VECTOR after reset) and load_count (32 bits, loads since reset, wraps FFFF_FFFF->0).
- REQ-020 SHALL, when PC_TRACE_EN is undefined, omit prev_pc and load_count ports and logic entirely; all other behaviour identical.

Structure
- REQ-021 SHALL take XLEN default, RESET_VECTOR default and INSN_BYTES=4 from shared package pc_pkg.
- REQ-022 SHALL implement trace logic (REQ-019) in sub-module pc_trace, instantiated only under PC_TRACE_EN.
- REQ-023 SHALL contain no other sub-modules; PC register and pc_plus4 adder reside in pc.

Verification
- REQ-024 SHALL check reset: reset=0 with clk running -> pc_out=0, pc_plus4=4, pc_valid=0, misaligned=0, asynchronously without an edge.
- REQ-025 SHALL check sequential load: reset=1, next_pc=4,8,C,10 on successive edges -> pc_out=4,8,C,10 one cycle later each; pc_valid=1 from first edge.
- REQ-026 SHALL check misalignment: next_pc=32'h0000_0106 -> pc_out=32'h0000_0104, misaligned=1 for one cycle; next load 32'h0000_0108 -> misaligned=0.
- REQ-027 SHALL check wrap: next_pc=32'hFFFF_FFFC -> pc_plus4=0.
- REQ-028 SHALL check mid-run reset: reset=0 between edges while pc_out=32'h10 -> pc_out=0 immediately; reset=1 with next_pc=32'h20 -> pc_out=32'h20 after next edge.
- REQ-029 SHALL check PC_TRACE_EN: loads 4 then 8 -> prev_pc=4, load_count=2; reset -> prev_pc=0, load_count=0.
